alu_seq_ctrl: RTL and testbench

//   Parametrised sequencer for one ALU instruction: loads operand i (register), operand j (register or

---
 rtl/alu_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Single-instruction ALU sequencer: operand load, ALU input latch, multi-cycle execute,
// result capture, write-back and a one-cycle IF pulse. Outputs are decoded from a one-hot state.
//
// state  | meaning
// IDLE   | waiting for ALUstr
// LD1    | load operand i from register file
// LD2    | load operand j (register or data-bus immediate)
// IN1    | latch ALU input 1
// IN2    | latch ALU input 2
// EXEC   | wait ALU_LAT cycles
// OUT    | capture ALU result
// WB     | write result back to register file
// DONE   | IF pulse, request next instruction
module alu_seq_ctrl #(
    parameter int OPC_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int NOP_OPC = 0,
    parameter int CMP_OPC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ALUstr,
    input  logic [OPC_W-1:0] opCode,
    input  logic             abort,
    output logic             DIRiEn,
    output logic             DIRjEn,
    output logic             DBRjEn,
    output logic             RrEn,
    output logic             RwEn,
    output logic             ALUEnIn1,
    output logic             ALUEnIn2,
    output logic             ALUOutEn,
    output logic             IF,
    output logic             busy
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [8:0] {
        S_IDLE = 9'b000000001,
        S_LD1  = 9'b000000010,
        S_LD2  = 9'b000000100,
        S_IN1  = 9'b000001000,
        S_IN2  = 9'b000010000,
        S_EXEC = 9'b000100000,
        S_OUT  = 9'b001000000,
        S_WB   = 9'b010000000,
        S_DONE = 9'b100000000
    } state_t;

    state_t             state_q, state_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               imm;

    assign imm = opc_q[OPC_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ALUstr) begin
                        opc_d   = opCode;
                        state_d = (opCode == OPC_W'(NOP_OPC)) ? S_DONE : S_LD1;
                    end
                end
                S_LD1:  state_d = S_LD2;
                S_LD2:  state_d = S_IN1;
                S_IN1:  state_d = S_IN2;
                S_IN2:  state_d = S_EXEC;
                S_EXEC: begin
                    if (lat_cnt_q == CNT_W'(ALU_LAT - 1)) state_d = S_OUT;
                end
                S_OUT:  state_d = (opc_q == OPC_W'(CMP_OPC)) ? S_DONE : S_WB;
                S_WB:   state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        // counter only runs while staying in EXEC; any other path reloads zero
        lat_cnt_d = (state_q == S_EXEC && state_d == S_EXEC) ? lat_cnt_q + CNT_W'(1) : '0;
    end

    always_comb begin
        DIRiEn   = 1'b0;
        DIRjEn   = 1'b0;
        DBRjEn   = 1'b0;
        RrEn     = 1'b0;
        RwEn     = 1'b0;
        ALUEnIn1 = 1'b0;
        ALUEnIn2 = 1'b0;
        ALUOutEn = 1'b0;
        IF       = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_LD1: begin
                DIRiEn = 1'b1;
                RrEn   = 1'b1;
            end
            S_LD2: begin
                DIRjEn = ~imm;
                RrEn   = ~imm;
                DBRjEn = imm;
            end
            S_IN1:  ALUEnIn1 = 1'b1;
            S_IN2:  ALUEnIn2 = 1'b1;
            S_OUT:  ALUOutEn = 1'b1;
            S_WB:   RwEn     = 1'b1;
            S_DONE: IF       = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed-vector bench for alu_seq_ctrl: one instance with ALU_LAT=1, one with ALU_LAT=3.
module tb_alu_seq_ctrl;

    // output vector {busy, IF, ALUOutEn, ALUEnIn2, ALUEnIn1, RwEn, RrEn, DBRjEn, DIRjEn, DIRiEn}
    localparam logic [9:0] E_IDLE = 10'b0000000000;
    localparam logic [9:0] E_LD1  = 10'b1000001001;
    localparam logic [9:0] E_LD2R = 10'b1000001010;
    localparam logic [9:0] E_LD2I = 10'b1000000100;
    localparam logic [9:0] E_IN1  = 10'b1000100000;
    localparam logic [9:0] E_IN2  = 10'b1001000000;
    localparam logic [9:0] E_EXEC = 10'b1000000000;
    localparam logic [9:0] E_OUT  = 10'b1010000000;
    localparam logic [9:0] E_WB   = 10'b1000010000;
    localparam logic [9:0] E_DONE = 10'b1100000000;

    typedef struct {
        logic       str;
        logic [3:0] opc;
        logic       abrt;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       str1 = 1'b0, abort1 = 1'b0;
    logic [3:0] opc1 = 4'd0;
    logic       str3 = 1'b0, abort3 = 1'b0;
    logic [3:0] opc3 = 4'd0;
    logic d1_diri, d1_dirj, d1_dbrj, d1_rr, d1_rw, d1_in1, d1_in2, d1_out, d1_if, d1_busy;
    logic d3_diri, d3_dirj, d3_dbrj, d3_rr, d3_rw, d3_in1, d3_in2, d3_out, d3_if, d3_busy;
    logic [9:0] out1, out3;

    assign out1 = {d1_busy, d1_if, d1_out, d1_in2, d1_in1, d1_rw, d1_rr, d1_dbrj, d1_dirj, d1_diri};
    assign out3 = {d3_busy, d3_if, d3_out, d3_in2, d3_in1, d3_rw, d3_rr, d3_dbrj, d3_dirj, d3_diri};

    alu_seq_ctrl #(.OPC_W(4), .ALU_LAT(1), .NOP_OPC(0), .CMP_OPC(2)) dut1 (
        .clk(clk), .reset(reset), .ALUstr(str1), .opCode(opc1), .abort(abort1),
        .DIRiEn(d1_diri), .DIRjEn(d1_dirj), .DBRjEn(d1_dbrj), .RrEn(d1_rr), .RwEn(d1_rw),
        .ALUEnIn1(d1_in1), .ALUEnIn2(d1_in2), .ALUOutEn(d1_out), .IF(d1_if), .busy(d1_busy)
    );

    alu_seq_ctrl #(.OPC_W(4), .ALU_LAT(3), .NOP_OPC(0), .CMP_OPC(2)) dut3 (
        .clk(clk), .reset(reset), .ALUstr(str3), .opCode(opc3), .abort(abort3),
        .DIRiEn(d3_diri), .DIRjEn(d3_dirj), .DBRjEn(d3_dbrj), .RrEn(d3_rr), .RwEn(d3_rw),
        .ALUEnIn1(d3_in1), .ALUEnIn2(d3_in2), .ALUOutEn(d3_out), .IF(d3_if), .busy(d3_busy)
    );

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tab1[$];
    vec_t tab3[$];

    function automatic vec_t mk(input logic s, input logic [3:0] o, input logic a, input logic [9:0] e);
        vec_t v;
        v.str  = s;
        v.opc  = o;
        v.abrt = a;
        v.exp  = e;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: outputs %b, expected %b", nm, idx, act, exp);
        end
    endtask

    // inputs are held across one rising edge, outputs sampled 1 time unit after it
    task automatic step(input int sel, input logic s, input logic [3:0] o, input logic a);
        if (sel == 1) begin
            str1 = s; opc1 = o; abort1 = a;
        end else begin
            str3 = s; opc3 = o; abort3 = a;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_lat1", 0, out1, E_IDLE);
        check("reset_lat3", 0, out3, E_IDLE);
        reset = 1'b1;

        // basic reg op
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));
        tab1.push_back(mk(1'b1, 4'b0001, 1'b0, E_LD1));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_LD2R));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN1));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN2));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_OUT));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_WB));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_DONE));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));
        // compare: no write-back
        tab1.push_back(mk(1'b1, 4'b0010, 1'b0, E_LD1));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_LD2R));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN1));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN2));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_OUT));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_DONE));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));
        // no-op
        tab1.push_back(mk(1'b1, 4'b0000, 1'b0, E_DONE));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));
        // ALUstr held, opcode toggling: captured opcode rules
        tab1.push_back(mk(1'b1, 4'b0001, 1'b0, E_LD1));
        tab1.push_back(mk(1'b1, 4'b1001, 1'b0, E_LD2R));
        tab1.push_back(mk(1'b1, 4'b0010, 1'b0, E_IN1));
        tab1.push_back(mk(1'b1, 4'b0000, 1'b0, E_IN2));
        tab1.push_back(mk(1'b1, 4'b1001, 1'b0, E_EXEC));
        tab1.push_back(mk(1'b1, 4'b0010, 1'b0, E_OUT));
        tab1.push_back(mk(1'b1, 4'b0000, 1'b0, E_WB));
        tab1.push_back(mk(1'b1, 4'b1001, 1'b0, E_DONE));
        tab1.push_back(mk(1'b1, 4'b1010, 1'b0, E_IDLE));
        tab1.push_back(mk(1'b1, 4'b1010, 1'b0, E_LD1));
        tab1.push_back(mk(1'b1, 4'b0001, 1'b0, E_LD2I));
        tab1.push_back(mk(1'b1, 4'b0010, 1'b0, E_IN1));
        tab1.push_back(mk(1'b1, 4'b0000, 1'b0, E_IN2));
        tab1.push_back(mk(1'b1, 4'b0001, 1'b0, E_EXEC));
        tab1.push_back(mk(1'b1, 4'b0010, 1'b0, E_OUT));
        tab1.push_back(mk(1'b1, 4'b1001, 1'b0, E_WB));
        tab1.push_back(mk(1'b1, 4'b0000, 1'b0, E_DONE));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));
        // abort in IN2, then abort beats start in IDLE
        tab1.push_back(mk(1'b1, 4'b0001, 1'b0, E_LD1));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_LD2R));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN1));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN2));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b1, E_IDLE));
        tab1.push_back(mk(1'b1, 4'b0001, 1'b1, E_IDLE));
        tab1.push_back(mk(1'b1, 4'b0000, 1'b1, E_IDLE));
        tab1.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));

        // immediate with ALU_LAT=3
        tab3.push_back(mk(1'b1, 4'b1001, 1'b0, E_LD1));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_LD2I));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN1));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN2));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_OUT));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_WB));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_DONE));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));
        // abort mid-EXEC, then a full run must still spend three EXEC cycles
        tab3.push_back(mk(1'b1, 4'b0001, 1'b0, E_LD1));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_LD2R));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN1));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN2));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b1, E_IDLE));
        tab3.push_back(mk(1'b1, 4'b0010, 1'b0, E_LD1));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_LD2R));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN1));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IN2));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_EXEC));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_OUT));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_DONE));
        tab3.push_back(mk(1'b0, 4'b0000, 1'b0, E_IDLE));

        for (int i = 0; i < tab1.size(); i++) begin
            step(1, tab1[i].str, tab1[i].opc, tab1[i].abrt);
            check("lat1_vec", i, out1, tab1[i].exp);
        end
        for (int i = 0; i < tab3.size(); i++) begin
            step(3, tab3[i].str, tab3[i].opc, tab3[i].abrt);
            check("lat3_vec", i, out3, tab3[i].exp);
        end

        // reset asserted while dut3 is in EXEC: outputs must drop without a clock edge
        step(3, 1'b1, 4'b0001, 1'b0);
        step(3, 1'b0, 4'b0000, 1'b0);
        step(3, 1'b0, 4'b0000, 1'b0);
        step(3, 1'b0, 4'b0000, 1'b0);
        step(3, 1'b0, 4'b0000, 1'b0);
        check("pre_reset_exec", 0, out3, E_EXEC);
        reset = 1'b0;
        #1;
        check("async_reset_lat3", 0, out3, E_IDLE);
        check("async_reset_lat1", 0, out1, E_IDLE);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(3, 1'b0, 4'b0000, 1'b0);
            check("post_reset_idle", i, out3, E_IDLE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
